// File: rtl/crp16_mul_seq_pkg.sv
// Shared definitions for the crp16 ALU and the sequential multiplier that borrows it.
package crp16_mul_seq_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SEL_W  = 3;

  localparam logic [SEL_W-1:0] ALU_LSR = 3'b000;
  localparam logic [SEL_W-1:0] ALU_ASR = 3'b001;
  localparam logic [SEL_W-1:0] ALU_LSL = 3'b010;
  localparam logic [SEL_W-1:0] ALU_AND = 3'b011;
  localparam logic [SEL_W-1:0] ALU_OR  = 3'b100;
  localparam logic [SEL_W-1:0] ALU_XOR = 3'b101;
  localparam logic [SEL_W-1:0] ALU_ADD = 3'b110;
  localparam logic [SEL_W-1:0] ALU_SUB = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_ADD  = 3'd2,
    ST_SHL  = 3'd3,
    ST_SHR  = 3'd4,
    ST_DONE = 3'd5
  } mul_state_t;

endpackage

// File: rtl/crp16_alu.sv
// Combinational 16-bit ALU shared between the execute stage and the multiplier.
module crp16_alu
  import crp16_mul_seq_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] res,
  output logic              c,
  output logic              v,
  output logic              n,
  output logic              z
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide = '0;
    c    = 1'b0;
    v    = 1'b0;
    case (sel)
      ALU_LSR: begin
        wide = {1'b0, x >> y[3:0]};
        c    = (y[3:0] != 4'd0) ? x[y[3:0] - 4'd1] : 1'b0;
      end
      ALU_ASR: wide = {1'b0, DATA_W'($signed(x) >>> y[3:0])};
      ALU_LSL: begin
        wide = {1'b0, x << y[3:0]};
        c    = (y[3:0] != 4'd0) ? x[5'd16 - 5'(y[3:0])] : 1'b0;
      end
      ALU_AND: wide = {1'b0, x & y};
      ALU_OR:  wide = {1'b0, x | y};
      ALU_XOR: wide = {1'b0, x ^ y};
      ALU_ADD: begin
        wide = {1'b0, x} + {1'b0, y};
        c    = wide[DATA_W];
        v    = (x[DATA_W-1] == y[DATA_W-1]) && (wide[DATA_W-1] != x[DATA_W-1]);
      end
      default: begin
        wide = {1'b0, x} - {1'b0, y};
        c    = ~wide[DATA_W];
        v    = (x[DATA_W-1] != y[DATA_W-1]) && (wide[DATA_W-1] != x[DATA_W-1]);
      end
    endcase
    res = wide[DATA_W-1:0];
    n   = res[DATA_W-1];
    z   = (res == '0);
  end

endmodule

// File: rtl/crp16_mul_seq.sv
// Shift-and-add 16x16 multiplier (low 16 bits + overflow) that time-shares the crp16 ALU.
module crp16_mul_seq
  import crp16_mul_seq_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  output logic              alu_req,
  input  logic              alu_gnt,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_c
);

  mul_state_t        state, state_nx;
  logic [DATA_W-1:0] acc, acc_nx;
  logic [DATA_W-1:0] mc, mc_nx;
  logic [DATA_W-1:0] mp, mp_nx;
  logic              ovf_r, ovf_r_nx;
  logic [DATA_W-1:0] result_nx;
  logic              ovf_nx;

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      acc    <= '0;
      mc     <= '0;
      mp     <= '0;
      ovf_r  <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_nx;
      acc    <= acc_nx;
      mc     <= mc_nx;
      mp     <= mp_nx;
      ovf_r  <= ovf_r_nx;
      result <= result_nx;
      ovf    <= ovf_nx;
    end
  end

  // Next state, ALU request and datapath updates; outputs decode only registered state
  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    mc_nx     = mc;
    mp_nx     = mp;
    ovf_r_nx  = ovf_r;
    result_nx = result;
    ovf_nx    = ovf;
    busy      = (state != ST_IDLE);
    done      = 1'b0;
    alu_req   = 1'b0;
    alu_x     = '0;
    alu_y     = '0;
    alu_sel   = ALU_LSR;

    case (state)
      ST_IDLE: begin
        if (start) begin
          acc_nx   = '0;
          mc_nx    = op_a;
          mp_nx    = op_b;
          ovf_r_nx = 1'b0;
          state_nx = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // Result is loaded on entry to DONE so it is already valid while done is high
        if (mp == '0) begin
          result_nx = acc;
          ovf_nx    = ovf_r;
          state_nx  = ST_DONE;
        end else if (mp[0]) begin
          state_nx = ST_ADD;
        end else begin
          state_nx = ST_SHL;
        end
      end
      ST_ADD: begin
        alu_req = 1'b1;
        alu_x   = acc;
        alu_y   = mc;
        alu_sel = ALU_ADD;
        if (alu_gnt) begin
          acc_nx   = alu_out;
          ovf_r_nx = ovf_r | alu_c;
          state_nx = ST_SHL;
        end
      end
      ST_SHL: begin
        alu_req = 1'b1;
        alu_x   = mc;
        alu_y   = DATA_W'(1);
        alu_sel = ALU_LSL;
        // A multiplicand bit pushed out matters only if higher multiplier bits remain
        if (alu_gnt) begin
          mc_nx    = alu_out;
          ovf_r_nx = ovf_r | (mc[DATA_W-1] & (mp[DATA_W-1:1] != '0));
          state_nx = ST_SHR;
        end
      end
      ST_SHR: begin
        alu_req = 1'b1;
        alu_x   = mp;
        alu_y   = DATA_W'(1);
        alu_sel = ALU_LSR;
        if (alu_gnt) begin
          mp_nx    = alu_out;
          state_nx = ST_SCAN;
        end
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_crp16_mul_seq.sv
// Directed bench for crp16_mul_seq wired to a real crp16_alu.
module tb_crp16_mul_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        ovf;
  logic        alu_req;
  logic        alu_gnt;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [2:0]  alu_sel;
  logic [15:0] alu_out;
  logic        alu_c;
  logic        alu_v;
  logic        alu_n;
  logic        alu_z;

  int n_cmp    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int done_cnt = 0;
  bit req_seen = 1'b0;

  crp16_mul_seq dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .ovf     (ovf),
    .alu_req (alu_req),
    .alu_gnt (alu_gnt),
    .alu_x   (alu_x),
    .alu_y   (alu_y),
    .alu_sel (alu_sel),
    .alu_out (alu_out),
    .alu_c   (alu_c)
  );

  crp16_alu alu (
    .x   (alu_x),
    .y   (alu_y),
    .sel (alu_sel),
    .res (alu_out),
    .c   (alu_c),
    .v   (alu_v),
    .n   (alu_n),
    .z   (alu_z)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (done) done_cnt++;
    if (alu_req) req_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle start pulse; afterwards the bench sits in cycle 1
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int guard;
    guard = 0;
    while (!done && guard < 400) begin
      tick();
      guard++;
    end
    lat = done ? cyc : -1;
  endtask

  initial begin
    logic [3:0] path [13];
    int lat;
    int base;
    path = '{4'h0, 4'hE, 4'hA, 4'h8, 4'h0, 4'hA, 4'h8, 4'h0, 4'hE, 4'hA, 4'h8, 4'h0, 4'h0};

    reset   = 1'b1;
    start   = 1'b0;
    alu_gnt = 1'b1;
    op_a    = '0;
    op_b    = '0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_ovf", ovf, 0);
    check("rst_req", alu_req, 0);
    reset = 1'b0;
    tick();

    // 3*5 with full grant: check the state path through req/sel each cycle
    launch(16'd3, 16'd5);
    for (int i = 0; i < 13; i++) begin
      check($sformatf("path%0d", i + 1), {alu_req, alu_sel}, path[i]);
      check($sformatf("done_c%0d", i + 1), done, (i == 12) ? 1 : 0);
      check($sformatf("busy_c%0d", i + 1), busy, 1);
      if (i < 12) tick();
    end
    check("mul3x5_result", result, 15);
    check("mul3x5_ovf", ovf, 0);
    tick();
    check("idle_busy", busy, 0);
    check("idle_result_hold", result, 15);

    // Zero multiplier never touches the ALU
    req_seen = 1'b0;
    launch(16'h1234, 16'h0000);
    check("zero_c1_done", done, 0);
    tick();
    check("zero_c2_done", done, 1);
    check("zero_result", result, 0);
    check("zero_ovf", ovf, 0);
    tick();
    check("zero_no_req", req_seen, 0);

    launch(16'h0100, 16'h0100);
    wait_done(lat);
    check("x100_lat", lat, 30);
    check("x100_result", result, 16'h0000);
    check("x100_ovf", ovf, 1);
    tick();

    launch(16'hFFFF, 16'd2);
    wait_done(lat);
    check("ffffx2_lat", lat, 9);
    check("ffffx2_result", result, 16'hFFFE);
    check("ffffx2_ovf", ovf, 1);
    tick();

    launch(16'hFFFF, 16'd1);
    wait_done(lat);
    check("ffffx1_lat", lat, 6);
    check("ffffx1_result", result, 16'hFFFF);
    check("ffffx1_ovf", ovf, 0);
    tick();

    // Grant withheld for 4 cycles in the first ADD
    launch(16'd3, 16'd5);
    check("stall_c1_req", alu_req, 0);
    tick();
    alu_gnt = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) alu_gnt = 1'b1;
      check($sformatf("stall%0d_req", k), alu_req, 1);
      check($sformatf("stall%0d_x", k), alu_x, 0);
      check($sformatf("stall%0d_y", k), alu_y, 3);
      check($sformatf("stall%0d_sel", k), alu_sel, 3'b110);
      if (k < 4) tick();
    end
    wait_done(lat);
    check("stall_lat", lat, 17);
    check("stall_result", result, 15);
    tick();

    // Starts while busy are dropped
    base = done_cnt;
    launch(16'd3, 16'd5);
    tick();
    tick();
    op_a  = 16'd7;
    op_b  = 16'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < 12) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_c13_done", done, 1);
    check("ign_result", result, 15);
    tick();
    tick();
    tick();
    check("ign_busy", busy, 0);
    check("ign_one_done", done_cnt - base, 1);
    check("ign_result_hold", result, 15);

    // Reset in the second SHL aborts with no done
    launch(16'd3, 16'd5);
    while (cyc < 6) tick();
    check("abort_in_shl", {alu_req, alu_sel}, 4'hA);
    base  = done_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    check("abort_ovf", ovf, 0);
    check("abort_req", alu_req, 0);
    check("abort_done", done, 0);
    tick();
    tick();
    check("abort_no_done", done_cnt - base, 0);

    launch(16'd7, 16'd9);
    wait_done(lat);
    check("mul7x9_lat", lat, 16);
    check("mul7x9_result", result, 63);
    check("mul7x9_ovf", ovf, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/crp16_mul_seq.md
Name: crp16_mul_seq

Overview:
- Multi-cycle unsigned 16x16 multiplier with a low-16 result. It owns no adder and instead drives a shared crp16_alu through a request/grant port.
- Implements shift-and-add by issuing ADD, LSL and LSR operations to the ALU, one per granted cycle.
- Sits beside the CPU execute stage. The ALU arbiter grants it the ALU only in cycles when the main pipeline does not need it.

Parameters:
- none. Width is fixed at 16 to match crp16_alu.

Ports:
- clock     in   1   system clock, rising edge
- reset     in   1   synchronous, active-high reset
- start     in   1   request a multiply; sampled only in IDLE
- op_a      in   16  multiplicand, captured on an accepted start
- op_b      in   16  multiplier, captured on an accepted start
- busy      out  1   high whenever state != IDLE
- done      out  1   one-cycle pulse; result and ovf are valid in that cycle
- result    out  16  low 16 bits of op_a*op_b; holds until the next accepted start
- ovf       out  1   unsigned overflow: the true product is >= 2^16; holds with result
- alu_req   out  1   high in ADD, SHL and SHR states
- alu_gnt   in   1   arbiter grant; an ALU operation completes only when alu_req && alu_gnt
- alu_x     out  16  ALU operand x; 0 when alu_req=0
- alu_y     out  16  ALU operand y; 0 when alu_req=0
- alu_sel   out  3   ALU select; 3'b000 when alu_req=0
- alu_out   in   16  ALU result (combinational, same cycle)
- alu_c     in   1   ALU carry-out

Behaviour:
- Reset (synchronous, active-high): state=IDLE, acc=mc=mp=0, result=0, ovf=0, done=0, busy=0, alu_req=0. Reset wins over every other input. Reset mid-operation aborts immediately with no done pulse.
- Internal registers: acc (running product), mc (shifted multiplicand), mp (shifted multiplier), ovf_r.
- IDLE: on start=1, load acc=0, mc=op_a, mp=op_b, ovf_r=0, then go to SCAN. start in any other state is ignored and not queued.
- SCAN (no ALU use):
  - mp==0 -> DONE
  - mp[0]==1 -> ADD
  - otherwise -> SHL
- ADD: alu_x=acc, alu_y=mc, alu_sel=3'b110. When granted: acc<=alu_out, ovf_r<=ovf_r|alu_c, go to SHL.
- SHL: alu_x=mc, alu_y=16'd1, alu_sel=3'b010. When granted: mc<=alu_out, ovf_r<=ovf_r|(mc[15] & (mp[15:1]!=0)), go to SHR.
- SHR: alu_x=mp, alu_y=16'd1, alu_sel=3'b000. When granted: mp<=alu_out, go to SCAN.
- Stall: in ADD, SHL or SHR with alu_gnt=0, hold state and all registers, and keep driving the same alu_x/alu_y/alu_sel.
- DONE: done=1, result<=acc, ovf<=ovf_r (registered, so visible in the DONE cycle), then go to IDLE. A start arriving while in DONE is ignored.
- Latency with no stalls, counted in cycles after the start edge until the done cycle inclusive:
  - 2 + sum over processed bits of (3 + bit value)
  - processed bits = positions 0..msb(op_b); 2 cycles when op_b=0
- Each stalled cycle adds exactly 1.
- The ALU v/n/z flags are unused.

Decomposition:
- Shared include file crp16_alu_ops.vh, guarded the same way as crp16_alu.v. It holds:
  - ALU select constants: LSR=3'b000, ASR=3'b001, LSL=3'b010, AND=3'b011, OR=3'b100, XOR=3'b101, ADD=3'b110, SUB=3'b111
  - state encodings for this block
- No sub-module. crp16_alu is instantiated outside, behind the arbiter.
- The bench instantiates crp16_alu directly, wired to alu_x/alu_y/alu_sel/alu_out/alu_c.

Test Plan:
- op_a=3, op_b=5, alu_gnt=1 -> done in the 13th cycle after start; result=15, ovf=0; state path SCAN,ADD,SHL,SHR,SCAN,SHL,SHR,SCAN,ADD,SHL,SHR,SCAN,DONE.
- op_a=0x1234, op_b=0 -> done in cycle 2, result=0, ovf=0, alu_req never asserted. Then op_a=0x0100, op_b=0x0100 -> result=0x0000, ovf=1.
- op_a=0xFFFF, op_b=2 -> result=0xFFFE, ovf=1 (overflow from the discarded mc[15]). op_a=0xFFFF, op_b=1 -> result=0xFFFF, ovf=0.
- op_a=3, op_b=5, alu_gnt low for 4 cycles during the first ADD -> alu_x/alu_y/alu_sel stable throughout, done in cycle 17, result=15.
- Pulse start again in cycles 3 and 12 of a 3*5 operation -> both ignored; exactly one done pulse; result=15 held afterwards.
- Assert reset during the second SHL of 3*5 -> next cycle busy=0, result=0, ovf=0, alu_req=0, no done pulse. A subsequent 7*9 completes with result=63.
